// File: rtl/fp_class_pipe.sv
// fp_class_pipe: registered one-hot FP classifier with valid/ready handshake; FP_CLASS_STATS_EN adds per-class saturating counters
module fp_class_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_f,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_f,
`ifdef FP_CLASS_STATS_EN
  input  logic                   stat_clr,
  input  logic [3:0]             stat_sel,
  output logic [CNT_W-1:0]       stat_cnt,
`endif
  output logic [9:0]             out_class
);
  if (EXP_W < 2 || MAN_W < 2 || CNT_W < 1) begin : g_bad_cfg
    $error("fp_class_pipe: EXP_W and MAN_W must be >= 2, CNT_W >= 1");
  end
  logic             sgn, exp_ones, exp_zero, sig_zero, qbit, acc;
  logic [EXP_W-1:0] exp;
  logic [MAN_W-1:0] man;
  logic [9:0]       cls;
  assign {sgn, exp, man} = in_f;
  assign exp_ones = &exp;
  assign exp_zero = ~|exp;
  assign sig_zero = ~|man;
  assign qbit     = man[MAN_W-1];
  assign in_ready = ~out_valid | out_ready;
  assign acc      = in_valid & in_ready;
  // NaNs ignore the sign; every other class is split by sign
  always_comb begin
    cls = {exp_ones & qbit,
           exp_ones & ~qbit & ~sig_zero,
           ~sgn & exp_ones & sig_zero,
           ~sgn & ~exp_ones & ~exp_zero,
           ~sgn & exp_zero & ~sig_zero,
           ~sgn & exp_zero & sig_zero,
           sgn & exp_zero & sig_zero,
           sgn & exp_zero & ~sig_zero,
           sgn & ~exp_ones & ~exp_zero,
           sgn & exp_ones & sig_zero};
  end
  // output register: load on accept, drop valid on drain, hold under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_f     <= '0;
      out_class <= '0;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_f     <= in_f;
      out_class <= cls;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`ifdef FP_CLASS_STATS_EN
  logic [CNT_W-1:0] cnt [10];
  assign stat_cnt = (stat_sel < 4'd10) ? cnt[stat_sel] : '0;
  // saturating per-class counters; clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      for (int i = 0; i < 10; i++) cnt[i] <= '0;
    end else if (acc) begin
      for (int i = 0; i < 10; i++) if (cls[i] && !(&cnt[i])) cnt[i] <= cnt[i] + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_fp_class_pipe.sv
// tb_fp_class_pipe: randomized and directed checks of fp_class_pipe against a field-value reference model
module tb_fp_class_pipe;
  logic        clk = 0, rst = 1;
  logic        in_valid = 0, out_ready = 1;
  logic [15:0] in_f = 0;
  logic        in_ready, out_valid;
  logic [15:0] out_f;
  logic [9:0]  out_class;
  logic        d_in_valid = 0, d_in_ready, d_out_valid;
  logic [63:0] d_in_f = 0, d_out_f;
  logic [9:0]  d_out_class;
  int tests = 0, fails = 0;
`ifdef FP_CLASS_STATS_EN
  logic       stat_clr = 0;
  logic [3:0] stat_sel = 0;
  logic [1:0] stat_cnt;
`endif

  always #5 clk = ~clk;

  fp_class_pipe #(.EXP_W(5), .MAN_W(10), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_f(in_f),
    .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f),
`ifdef FP_CLASS_STATS_EN
    .stat_clr(stat_clr), .stat_sel(stat_sel), .stat_cnt(stat_cnt),
`endif
    .out_class(out_class));

  fp_class_pipe #(.EXP_W(11), .MAN_W(52)) dp (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_f(d_in_f),
    .out_valid(d_out_valid), .out_ready(1'b1), .out_f(d_out_f),
`ifdef FP_CLASS_STATS_EN
    .stat_clr(1'b0), .stat_sel(4'd0), .stat_cnt(),
`endif
    .out_class(d_out_class));

  function automatic int ref_idx(input logic [63:0] f, input int ew, input int mw);
    longint unsigned e, m, emax;
    bit s;
    s    = f[ew+mw];
    emax = (64'd1 << ew) - 1;
    e    = (f >> mw) & emax;
    m    = f & ((64'd1 << mw) - 1);
    if (e == emax) begin
      if (m == 0) return s ? 0 : 7;
      return (m >= (64'd1 << (mw - 1))) ? 9 : 8;
    end
    if (e == 0) return (m == 0) ? (s ? 3 : 4) : (s ? 2 : 5);
    return s ? 1 : 6;
  endfunction

  function automatic logic [9:0] ref_class(input logic [63:0] f, input int ew, input int mw);
    return 10'd1 << ref_idx(f, ew, mw);
  endfunction

  function automatic logic [15:0] rnd_op();
    logic [4:0] e;
    logic [9:0] m;
    int k;
    k = $urandom_range(0, 3);
    e = (k == 0) ? 5'd0 : (k == 1) ? 5'd31 : 5'($urandom);
    k = $urandom_range(0, 3);
    m = (k == 0) ? 10'd0 : (k == 1) ? 10'h200 : (k == 2) ? 10'($urandom_range(1, 511)) : 10'($urandom);
    return {1'($urandom), e, m};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 0; out_ready = 0;
    tick(); tick();
    tests++;
    if (out_valid !== 1'b0 || out_class !== 10'd0 || out_f !== 16'd0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset: valid=%b class=%h f=%h ready=%b, need 0/000/0000/1", out_valid, out_class, out_f, in_ready);
    end
    rst = 0; out_ready = 1;
  endtask

  task automatic test_class_table();
    logic [15:0] ops [10] = '{16'h7C00, 16'hFC00, 16'h7E00, 16'hFD00, 16'h0000,
                              16'h8000, 16'h8001, 16'h03FF, 16'h3C00, 16'hBC00};
    logic [9:0]  exp [10] = '{10'h080, 10'h001, 10'h200, 10'h100, 10'h010,
                              10'h008, 10'h004, 10'h020, 10'h040, 10'h002};
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_f = ops[i];
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_class !== exp[i] || out_f !== ops[i]) begin
        fails++;
        $display("FAIL class_table %h: valid=%b class=%h f=%h, need 1/%h/%h", ops[i], out_valid, out_class, out_f, exp[i], ops[i]);
      end
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_backpressure();
    in_valid = 1; in_f = 16'h3C00; out_ready = 1;
    tick();
    out_ready = 0; in_f = 16'h7C00;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_ready cyc%0d: in_ready=%b need 0", i, in_ready);
      end
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_class !== 10'h040 || out_f !== 16'h3C00) begin
        fails++;
        $display("FAIL bp_hold cyc%0d: valid=%b class=%h f=%h need 1/040/3c00", i, out_valid, out_class, out_f);
      end
    end
    out_ready = 1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: in_ready=%b need 1", in_ready);
    end
    tick();
    in_valid = 0;
    tests++;
    if (out_valid !== 1'b1 || out_class !== 10'h080 || out_f !== 16'h7C00) begin
      fails++;
      $display("FAIL bp_after: valid=%b class=%h f=%h need 1/080/7c00", out_valid, out_class, out_f);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_drain: out_valid=%b need 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] op;
    out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      op = rnd_op();
      in_valid = 1; in_f = op;
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL stream_ready cyc%0d: in_ready=%b need 1", i, in_ready);
      end
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_class !== ref_class(64'(op), 5, 10) || out_f !== op) begin
        fails++;
        $display("FAIL stream cyc%0d %h: valid=%b class=%h need 1/%h", i, op, out_valid, out_class, ref_class(64'(op), 5, 10));
      end
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_random();
    bit          mv = 0, acc;
    logic [15:0] mf = 0, op;
    for (int i = 0; i < 400; i++) begin
      op = rnd_op();
      in_valid = 1'($urandom); in_f = op; out_ready = ($urandom_range(0, 3) != 0);
      #1;
      tests++;
      if (in_ready !== (!mv || out_ready)) begin
        fails++;
        $display("FAIL rand_ready %0d: in_ready=%b need %b", i, in_ready, !mv || out_ready);
      end
      acc = in_valid && (!mv || out_ready);
      if (acc) begin mv = 1; mf = op; end
      else if (out_ready) mv = 0;
      tick();
      tests++;
      if (out_valid !== mv || (mv && (out_f !== mf || out_class !== ref_class(64'(mf), 5, 10)))) begin
        fails++;
        $display("FAIL rand %0d: valid=%b f=%h class=%h need %b/%h/%h", i, out_valid, out_f, out_class, mv, mf, ref_class(64'(mf), 5, 10));
      end
    end
    in_valid = 0; out_ready = 1;
    tick();
  endtask

  task automatic test_mid_reset();
    in_valid = 1; in_f = 16'hBC00; out_ready = 1;
    tick();
    in_valid = 0; out_ready = 0; rst = 1;
    tick();
    rst = 0;
    tests++;
    if (out_valid !== 1'b0 || out_class !== 10'd0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset: valid=%b class=%h ready=%b need 0/000/1", out_valid, out_class, in_ready);
    end
    out_ready = 1;
  endtask

`ifdef FP_CLASS_STATS_EN
  task automatic test_stats();
    int          mc [10];
    logic [15:0] op;
    bit          mv = 0;
    out_ready = 1; stat_clr = 1;
    tick();
    stat_clr = 0;
    for (int i = 0; i < 5; i++) begin in_valid = 1; in_f = 16'h0000; tick(); end
    in_valid = 0; stat_sel = 4;
    #1;
    tests++;
    if (stat_cnt !== 2'd3) begin
      fails++;
      $display("FAIL stat_sat: stat_cnt=%0d need 3", stat_cnt);
    end
    stat_sel = 11;
    #1;
    tests++;
    if (stat_cnt !== 2'd0) begin
      fails++;
      $display("FAIL stat_sel_oob: stat_cnt=%0d need 0", stat_cnt);
    end
    stat_sel = 4; stat_clr = 1; in_valid = 1; in_f = 16'h0000;
    tick();
    stat_clr = 0; in_valid = 0;
    tests++;
    if (stat_cnt !== 2'd0) begin
      fails++;
      $display("FAIL stat_clr: stat_cnt=%0d need 0", stat_cnt);
    end
    tick();
    for (int k = 0; k < 10; k++) mc[k] = 0;
    for (int i = 0; i < 14; i++) begin
      op = rnd_op();
      in_valid = 1'($urandom); in_f = op; out_ready = 1'($urandom);
      #1;
      if (in_valid && (!mv || out_ready)) begin
        mv = 1;
        if (mc[ref_idx(64'(op), 5, 10)] < 3) mc[ref_idx(64'(op), 5, 10)]++;
      end else if (out_ready) mv = 0;
      tick();
    end
    in_valid = 0; out_ready = 1;
    for (int k = 0; k < 10; k++) begin
      stat_sel = 4'(k);
      #1;
      tests++;
      if (stat_cnt !== 2'(mc[k])) begin
        fails++;
        $display("FAIL stat_rand sel%0d: stat_cnt=%0d need %0d", k, stat_cnt, mc[k]);
      end
    end
    tick();
  endtask
`endif

  task automatic test_double();
    logic [63:0] ops [6];
    ops[0] = 64'h7FF4_0000_0000_0000;
    ops[1] = 64'h7FF8_0000_0000_0000;
    ops[2] = 64'hFFF0_0000_0000_0000;
    ops[3] = 64'h000F_FFFF_FFFF_FFFF;
    ops[4] = {$urandom, $urandom};
    ops[5] = 64'h8000_0000_0000_0000;
    for (int i = 0; i < 6; i++) begin
      d_in_valid = 1; d_in_f = ops[i];
      tick();
      tests++;
      if (d_out_valid !== 1'b1 || d_out_class !== ref_class(ops[i], 11, 52) || d_out_f !== ops[i]) begin
        fails++;
        $display("FAIL double %h: valid=%b class=%h need 1/%h", ops[i], d_out_valid, d_out_class, ref_class(ops[i], 11, 52));
      end
    end
    d_in_valid = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_class_table();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_mid_reset();
`ifdef FP_CLASS_STATS_EN
    test_stats();
`endif
    test_double();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fp_class_pipe.md
# fp_class_pipe

Parametrised, pipelined floating-point classifier for the FPU front end. Each operand is accepted on a valid/ready handshake and classified one cycle later into a 10-bit one-hot class mask with sign-split classes and a distinct sNaN/qNaN split. The output is registered so the block can sit directly between the operand queue and the FPU execute stage. An optional statistics unit keeps a saturating per-class count of classified operands.

## Interface
Parameters:
- EXP_W, default 5: exponent width. Use 8 for single precision and 11 for double.
- MAN_W, default 10: stored mantissa width, excluding the hidden bit.
- CNT_W, default 16: width of each statistics counter. Used only when FP_CLASS_STATS_EN is defined.

Ports (W = 1+EXP_W+MAN_W):
- clk, input, 1: clock. All logic is on the rising edge.
- rst, input, 1: synchronous reset, active-high.
- in_valid, input, 1: operand present.
- in_ready, output, 1: block can accept an operand.
- in_f, input, W: operand, laid out as {sign, exp, man}.
- out_valid, output, 1: result present.
- out_ready, input, 1: downstream accepts the result.
- out_f, output, W: operand passed through unchanged.
- out_class, output, 10: one-hot class mask.
- stat_clr, input, 1: clears all counters. Only exists when FP_CLASS_STATS_EN is defined.
- stat_sel, input, 4: selects a counter, 0..9. Only exists when FP_CLASS_STATS_EN is defined.
- stat_cnt, output, CNT_W: value of the selected counter. Only exists when FP_CLASS_STATS_EN is defined.

## Operation
- Field flags:
  - expOnes: all exp bits are 1.
  - expZeroes: all exp bits are 0.
  - sigZeroes: all man bits are 0.
  - qbit: man[MAN_W-1].
- out_class bit mapping:
  - bit0: negative infinity.
  - bit1: negative normal.
  - bit2: negative subnormal.
  - bit3: negative zero.
  - bit4: positive zero.
  - bit5: positive subnormal.
  - bit6: positive normal.
  - bit7: positive infinity.
  - bit8: sNaN, when expOnes & ~qbit & ~sigZeroes.
  - bit9: qNaN, when expOnes & qbit.
- NaN classes ignore the sign bit.
- Exactly one bit of out_class is set whenever out_valid=1.
- Pipeline register:
  - in_ready = ~out_valid | out_ready.
  - An accept occurs when in_valid & in_ready. On accept, out_f, out_class and out_valid=1 load on the next edge.
  - When out_valid & out_ready and there is no accept, out_valid clears.
  - out_f and out_class hold while out_valid=1 and out_ready=0.
- Throughput is one operand per cycle when out_ready is held at 1.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Reset values: out_valid=0, out_f=0, out_class=0, all counters 0.
- in_ready is combinational from out_valid and out_ready. During rst=1, in_ready follows that same equation but no accept takes effect.
- Reset mid-operation: any result held in the register is dropped. out_valid is 0 in the cycle after the reset edge.
- Simultaneous drain and accept: when out_valid & out_ready & in_valid, the register reloads and out_valid stays 1. No bubble is inserted.
- No output changes while out_valid=1 and out_ready=0. This holds regardless of in_valid.
- Counters:
  - The counter for the classified class increments on the accept edge.
  - Counters saturate at 2^CNT_W−1.
  - stat_clr has priority over an increment in the same cycle. That operand is not counted.
- stat_cnt:
  - stat_cnt is a combinational read of the counter selected by stat_sel.
  - If stat_sel ≥ 10, stat_cnt = 0.
  - An update is visible the cycle after the edge.

## Configuration
- FP_CLASS_STATS_EN defined:
  - The 10 saturating counters and the stat_clr, stat_sel and stat_cnt ports are present.
- FP_CLASS_STATS_EN undefined:
  - The counters and the three stat ports are absent.
  - The datapath and handshake behaviour is identical to the defined case.

## Test plan
- Class mapping, with EXP_W=5, MAN_W=10 and out_ready=1. Each operand gives the listed out_class value one cycle after accept, and out_f echoes the input:

  | in_f | out_class |
  |------|-----------|
  | 0x7C00 | 0x080 |
  | 0xFC00 | 0x001 |
  | 0x7E00 | 0x200 |
  | 0xFD00 | 0x100 |
  | 0x0000 | 0x010 |
  | 0x8000 | 0x008 |
  | 0x8001 | 0x004 |
  | 0x03FF | 0x020 |
  | 0x3C00 | 0x040 |
  | 0xBC00 | 0x002 |

- Backpressure:
  - Stimulus: accept 0x3C00, then hold out_ready=0 for 3 cycles while in_valid=1 with 0x7C00.
  - Required: in_ready=0 for those 3 cycles, and out_class stays 0x040.
  - Then raise out_ready: 0x7C00 is accepted, and out_class becomes 0x080 on the next cycle.
- Streaming:
  - Stimulus: 8 back-to-back operands with out_ready=1.
  - Required: in_ready stays 1 and out_valid stays 1 from cycle 1 to cycle 8, with no bubbles.
- Reset mid-operation:
  - Stimulus: assert rst while out_valid=1 and out_ready=0.
  - Required: after the edge, out_valid=0, out_class=0 and in_ready=1.
- Statistics, with FP_CLASS_STATS_EN defined and CNT_W=2:
  - Stimulus: accept 5 operands of 0x0000.
  - Required: with stat_sel=4, stat_cnt=3 (saturated).
  - Stimulus: pulse stat_clr in the same cycle as an accept of 0x0000.
  - Required: stat_cnt=0 afterwards.
- Double-precision build:
  - Stimulus: EXP_W=11, MAN_W=52, in_f=0x7FF4_0000_0000_0000.
  - Required: out_class=0x100.
  - Stimulus: in_f=0x7FF8_0000_0000_0000.
  - Required: out_class=0x200.
